// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and defaults for the two-master memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_e;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;
  localparam int          CNT_W             = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bundle of the arbiter's master, slave and status signals
interface mem_arbiter_if;

  logic        m0_valid;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ready;
  logic [31:0] m0_rdata;

  logic        m1_valid;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ready;
  logic [31:0] m1_rdata;

  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  logic [1:0]  grant;
  logic        err;
  logic        err_clr;

  // Requesting side: the masters, the slave response and the error clear.
  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output s_ready, s_rdata, err_clr,
    input  m0_ready, m0_rdata, m1_ready, m1_rdata,
    input  s_valid, s_addr, s_wdata, s_wstrb, grant, err
  );

  // Arbiter side.
  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  s_ready, s_rdata, err_clr,
    output m0_ready, m0_rdata, m1_ready, m1_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb, grant, err
  );

endinterface

// File: rtl/mem_arb_timeout.sv
// rtl/mem_arb_timeout.sv - per-grant cycle counter flagging the forced-completion cycle
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Holds at LIMIT rather than wrapping; the arbiter always leaves the grant there.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter onto one slave port, with access timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        err,
  input  logic        err_clr
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;   // 1 = m1 was granted last
  logic       err_q, err_d;
  logic       expired;

  mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .enable  (state_q != IDLE),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    err_d    = err_q & ~err_clr;
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_rdata = '0;

    case (state_q)
      IDLE: begin
        if (m0_valid && (!m1_valid || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_valid) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: begin
        s_valid = 1'b1;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
        // A slave response in the expiry cycle beats the forced error completion.
        if (s_ready) begin
          m0_ready = 1'b1;
          m0_rdata = s_rdata;
          state_d  = IDLE;
        end else if (expired) begin
          m0_ready = 1'b1;
          m0_rdata = ERR_RDATA;
          err_d    = 1'b1;
          state_d  = IDLE;
        end
      end
      GNT1: begin
        s_valid = 1'b1;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
        if (s_ready) begin
          m1_ready = 1'b1;
          m1_rdata = s_rdata;
          state_d  = IDLE;
        end else if (expired) begin
          m1_ready = 1'b1;
          m1_rdata = ERR_RDATA;
          err_d    = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Quiet the bus during reset so an abandoned transfer never shows a ready pulse.
    if (reset) begin
      s_valid  = 1'b0;
      s_addr   = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      m0_ready = 1'b0;
      m0_rdata = '0;
      m1_ready = 1'b0;
      m1_rdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign grant = state_q;
  assign err   = err_q;

endmodule
